// File: rtl/itcm_pkg.sv
// Shared types and constants for the ITCM AXI read slave: response/burst codes,
// read FSM states, R-beat record and the AR error decoder.
package itcm_pkg;

    localparam int INST_ADDR_WIDTH = 32;
    localparam int INST_DATA_WIDTH = 32;
    localparam int ITCM_ID_WIDTH   = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [2:0] SIZE_WORD   = 3'b010;

    typedef enum logic {
        IDLE,
        BURST
    } rd_state_e;

    typedef struct packed {
        logic [ITCM_ID_WIDTH-1:0]   id;
        logic [INST_DATA_WIDTH-1:0] data;
        logic [1:0]                 resp;
        logic                       last;
    } r_beat_t;

    // Window check takes priority over protocol errors; one code covers the whole burst.
    function automatic logic [1:0] decode_err(
        input logic [INST_ADDR_WIDTH-1:0] addr,
        input logic [2:0]                 size,
        input logic [1:0]                 burst,
        input logic [INST_ADDR_WIDTH-1:0] base,
        input logic [INST_ADDR_WIDTH:0]   win_bytes
    );
        logic [INST_ADDR_WIDTH:0] end_addr;
        end_addr = {1'b0, base} + win_bytes;
        if ((addr < base) || ({1'b0, addr} >= end_addr))
            return RESP_DECERR;
        if ((size != SIZE_WORD) || ((burst != BURST_FIXED) && (burst != BURST_INCR)) ||
            (addr[1:0] != 2'b00))
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/itcm_axi_rd_slave_rbuf.sv
// Two-entry FIFO of R beats; the head entry drives the AXI R channel.
// Push and pop in the same cycle are legal even when full.
module itcm_rbuf
    import itcm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  r_beat_t    push_beat,
    input  logic       pop,
    output r_beat_t    head,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            r_beat_t entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    entry_reg <= '0;
                else if (push && (wr_ptr_reg == 1'(gi)))
                    entry_reg <= push_beat;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
    assign count = count_reg;
    assign full  = (count_reg == 2'd2);
    assign empty = (count_reg == 2'd0);

endmodule

// File: rtl/itcm_axi_rd_slave.sv
// AXI4 read-only slave in front of the instruction TCM SRAM. One beat per cycle,
// in-order, with a one-stage SRAM read pipe feeding a 2-entry R buffer.
module itcm_axi_rd_slave
    import itcm_pkg::*;
#(
    parameter int                         MEM_DEPTH = 4096,
    parameter logic [INST_ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                         ID_WIDTH  = ITCM_ID_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ID_WIDTH-1:0]          S_AXI_ARID,
    input  logic [INST_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                   S_AXI_ARLEN,
    input  logic [2:0]                   S_AXI_ARSIZE,
    input  logic [1:0]                   S_AXI_ARBURST,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]          S_AXI_RID,
    output logic [INST_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RLAST,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    output logic                         sram_ce_o,
    output logic [$clog2(MEM_DEPTH)-1:0] sram_addr_o,
    input  logic [INST_DATA_WIDTH-1:0]   sram_rdata_i
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [INST_ADDR_WIDTH:0] WIN_BYTES = (INST_ADDR_WIDTH+1)'(4 * MEM_DEPTH);

    rd_state_e             state_reg, state_next;
    logic                  arready_en_reg;
    logic [ID_WIDTH-1:0]   id_reg;
    logic [AW-1:0]         addr_reg;
    logic [7:0]            cnt_reg;
    logic [1:0]            burst_reg;
    logic [1:0]            resp_reg;

    // Beat issued last cycle; its SRAM data (if any) is on sram_rdata_i now.
    logic                  pipe_valid_reg;
    logic [ID_WIDTH-1:0]   pipe_id_reg;
    logic [1:0]            pipe_resp_reg;
    logic                  pipe_last_reg;
    logic                  pipe_read_reg;

    logic                  ar_ready;
    logic                  ar_hs;
    logic                  issue;
    logic                  credit_ok;
    logic [AW-1:0]         ar_word;
    logic [1:0]            ar_err;

    r_beat_t               pipe_beat;
    r_beat_t               buf_head;
    r_beat_t               r_beat;
    logic                  buf_full, buf_empty;
    logic [1:0]            buf_count;
    logic                  fifo_pop, bypass_pop, buf_push;
    logic [2:0]            occ_next;

    assign ar_word = S_AXI_ARADDR[AW+1:2] - BASE_ADDR[AW+1:2];
    assign ar_err  = decode_err(S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST, BASE_ADDR, WIN_BYTES);

    // With an empty buffer the pipe beat goes straight to R, giving AR->R in two cycles.
    assign pipe_beat.id   = pipe_id_reg;
    assign pipe_beat.data = pipe_read_reg ? sram_rdata_i : '0;
    assign pipe_beat.resp = pipe_resp_reg;
    assign pipe_beat.last = pipe_last_reg;

    assign fifo_pop   = !buf_empty && S_AXI_RREADY;
    assign bypass_pop = buf_empty && pipe_valid_reg && S_AXI_RREADY;
    assign buf_push   = pipe_valid_reg && !bypass_pop && (!buf_full || fifo_pop);

    // A new beat may issue only if the buffer can still absorb it next cycle without a pop.
    assign occ_next  = {1'b0, buf_count} + {2'b00, buf_push} - {2'b00, fifo_pop};
    assign credit_ok = (occ_next <= 3'd1);

    always_comb begin
        state_next = state_reg;
        ar_ready   = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                ar_ready = arready_en_reg;
            end
            BURST: begin
                issue = credit_ok;
                if (issue && (cnt_reg == 8'd0)) begin
                    state_next = IDLE;
                    ar_ready   = arready_en_reg;
                end
            end
            default: state_next = IDLE;
        endcase
        if (ar_ready && S_AXI_ARVALID)
            state_next = BURST;
    end

    assign ar_hs = ar_ready && S_AXI_ARVALID;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            arready_en_reg <= 1'b0;
            id_reg         <= '0;
            addr_reg       <= '0;
            cnt_reg        <= 8'd0;
            burst_reg      <= BURST_FIXED;
            resp_reg       <= RESP_OKAY;
            pipe_valid_reg <= 1'b0;
            pipe_id_reg    <= '0;
            pipe_resp_reg  <= RESP_OKAY;
            pipe_last_reg  <= 1'b0;
            pipe_read_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            arready_en_reg <= 1'b1;
            pipe_valid_reg <= issue;
            if (issue) begin
                pipe_id_reg   <= id_reg;
                pipe_resp_reg <= resp_reg;
                pipe_last_reg <= (cnt_reg == 8'd0);
                pipe_read_reg <= (resp_reg == RESP_OKAY);
            end
            if (ar_hs) begin
                id_reg    <= S_AXI_ARID;
                addr_reg  <= ar_word;
                cnt_reg   <= S_AXI_ARLEN;
                burst_reg <= S_AXI_ARBURST;
                resp_reg  <= ar_err;
            end else if (issue) begin
                cnt_reg <= cnt_reg - 8'd1;
                if (burst_reg == BURST_INCR)
                    addr_reg <= addr_reg + 1'b1;
            end
        end
    end

    itcm_rbuf u_rbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .push_beat (pipe_beat),
        .pop       (fifo_pop),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign r_beat = buf_empty ? pipe_beat : buf_head;

    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = !buf_empty || pipe_valid_reg;
    assign S_AXI_RID     = r_beat.id;
    assign S_AXI_RDATA   = r_beat.data;
    assign S_AXI_RRESP   = r_beat.resp;
    assign S_AXI_RLAST   = r_beat.last;
    assign sram_ce_o     = issue && (resp_reg == RESP_OKAY);
    assign sram_addr_o   = addr_reg;

endmodule

// File: tb/tb_itcm_axi_rd_slave.sv
// Directed bench for itcm_axi_rd_slave: SRAM model, R-beat scoreboard, stall-hold
// monitor, and directed AR sequences including errors, backpressure and mid-burst reset.
module tb_itcm_axi_rd_slave;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'b010;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        sram_ce;
    logic [11:0] sram_addr;
    logic [31:0] sram_rdata = '0;

    logic [31:0] mem [4096];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ce_cnt   = 0;
    int n_id2    = 0;
    int t_last1  = -1;
    int t_first2 = -1;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } exp_t;
    exp_t exp_q[$];

    itcm_axi_rd_slave dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .S_AXI_ARID    (arid),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARSIZE  (arsize),
        .S_AXI_ARBURST (arburst),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RID     (rid),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RLAST   (rlast),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .sram_ce_o     (sram_ce),
        .sram_addr_o   (sram_addr),
        .sram_rdata_i  (sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_ce)
            sram_rdata <= mem[sram_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic push_exp(input logic [3:0] id, input int word, input int len,
                            input logic incr, input logic [1:0] resp);
        for (int i = 0; i <= len; i++) begin
            exp_t e;
            int   w;
            w      = incr ? ((word + i) % 4096) : word;
            e.id   = id;
            e.data = (resp == 2'b00) ? mem[w] : 32'h0;
            e.resp = resp;
            e.last = (i == len);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int waited = 0;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        #1;
        while (!arready && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("ar_accept", arready, 1'b1);
        @(posedge clk);
        #1 arvalid = 1'b0;
        $display("AR id=%0d addr=%08h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            @(negedge clk);
        @(negedge clk);
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    // Monitor: samples settled R/ce at negedge+1, i.e. the values the next posedge will see.
    logic        prev_stall = 1'b0;
    logic [38:0] prev_r = '0;
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (sram_ce)
                ce_cnt++;
            if (prev_stall) begin
                check("r_hold_valid", rvalid, 1'b1);
                check("r_hold", {rid, rdata, rresp, rlast}, prev_r);
            end
            if (rvalid && rready) begin
                exp_t e;
                e = '{id: 4'hx, data: 32'hx, resp: 2'hx, last: 1'bx};
                if (exp_q.size() != 0)
                    e = exp_q.pop_front();
                $display("R  id=%0d data=%08h resp=%0d last=%0b", rid, rdata, rresp, rlast);
                check("rid", rid, e.id);
                check("rdata", rdata, e.data);
                check("rresp", rresp, e.resp);
                check("rlast", rlast, e.last);
                if (rid == 4'd1 && rlast)
                    t_last1 = cyc;
                if (rid == 4'd2) begin
                    n_id2++;
                    if (t_first2 < 0)
                        t_first2 = cyc;
                end
            end
            prev_stall = rvalid && !rready;
            prev_r     = {rid, rdata, rresp, rlast};
        end
    end

    initial begin
        int c0;
        for (int i = 0; i < 4096; i++)
            mem[i] = 32'hC0DE_0000 | i;
        mem[4] = 32'hDEAD_BEEF;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_rid", rid, 4'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rresp", rresp, 2'b00);
        check("rst_ce", sram_ce, 1'b0);
        check("rst_arready", arready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arready_first_cycle", arready, 1'b0);
        @(negedge clk);
        #1;
        check("arready_after_reset", arready, 1'b1);

        // 1: single read, latency AR(N) -> ce(N+1) -> RVALID(N+2)
        push_exp(4'd5, 4, 0, 1'b1, 2'b00);
        do_ar(4'd5, BASE + 32'h10, 8'd0, 3'b010, 2'b01);
        @(negedge clk);
        #1;
        check("t1_ce", sram_ce, 1'b1);
        check("t1_addr", sram_addr, 12'd4);
        check("t1_rvalid_early", rvalid, 1'b0);
        @(negedge clk);
        #1;
        check("t1_rvalid", rvalid, 1'b1);
        check("t1_rdata", rdata, 32'hDEAD_BEEF);
        check("t1_rlast", rlast, 1'b1);
        drain("t1_drain");

        // 2: INCR 4 beats, ce for exactly 4 cycles
        c0 = ce_cnt;
        push_exp(4'd3, 0, 3, 1'b1, 2'b00);
        do_ar(4'd3, BASE, 8'd3, 3'b010, 2'b01);
        drain("t2_drain");
        check("t2_ce_cycles", ce_cnt - c0, 4);

        // 3: INCR 8 beats with RREADY toggling
        c0 = ce_cnt;
        push_exp(4'd6, 16, 7, 1'b1, 2'b00);
        do_ar(4'd6, BASE + 32'h40, 8'd7, 3'b010, 2'b01);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            rready = ~rready;
        end
        rready = 1'b1;
        drain("t3_drain");
        check("t3_ce_cycles", ce_cnt - c0, 8);

        // 4: outside window -> DECERR, no SRAM access
        c0 = ce_cnt;
        push_exp(4'd7, 0, 2, 1'b1, 2'b11);
        do_ar(4'd7, 32'h0000_1000, 8'd2, 3'b010, 2'b01);
        drain("t4_drain");
        check("t4_ce_cycles", ce_cnt - c0, 0);

        // Just past the window end -> DECERR
        push_exp(4'd8, 0, 0, 1'b1, 2'b11);
        do_ar(4'd8, BASE + 32'h4000, 8'd0, 3'b010, 2'b01);
        drain("t4b_drain");

        // 5: SLVERR cases and FIXED burst
        push_exp(4'd9, 0, 1, 1'b1, 2'b10);
        do_ar(4'd9, BASE, 8'd1, 3'b010, 2'b10);
        push_exp(4'd10, 0, 0, 1'b1, 2'b10);
        do_ar(4'd10, BASE + 32'h2, 8'd0, 3'b010, 2'b01);
        push_exp(4'd11, 0, 0, 1'b1, 2'b10);
        do_ar(4'd11, BASE, 8'd0, 3'b011, 2'b01);
        drain("t5_err_drain");
        push_exp(4'd12, 2, 1, 1'b0, 2'b00);
        do_ar(4'd12, BASE + 32'h8, 8'd1, 3'b010, 2'b00);
        drain("t5_fixed_drain");

        // INCR starting at the last word wraps to word 0
        push_exp(4'd13, 4095, 1, 1'b1, 2'b00);
        do_ar(4'd13, BASE + 32'h3FFC, 8'd1, 3'b010, 2'b01);
        drain("t5_wrap_drain");

        // 6: back-to-back IDs 1 then 2, then reset mid-burst
        push_exp(4'd1, 8, 3, 1'b1, 2'b00);
        push_exp(4'd2, 16, 7, 1'b1, 2'b00);
        do_ar(4'd1, BASE + 32'h20, 8'd3, 3'b010, 2'b01);
        do_ar(4'd2, BASE + 32'h40, 8'd7, 3'b010, 2'b01);
        for (int i = 0; i < 100 && n_id2 < 3; i++)
            @(negedge clk);
        check("t6_id2_progress", (n_id2 >= 3), 1'b1);
        check("t6_no_gap", t_first2 - t_last1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t6_rst_rvalid", rvalid, 1'b0);
        check("t6_rst_arready", arready, 1'b0);
        check("t6_rst_ce", sram_ce, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_arready_first", arready, 1'b0);
        check("t6_rvalid_after", rvalid, 1'b0);
        @(negedge clk);
        #1;
        check("t6_arready_after", arready, 1'b1);
        check("t6_buf_empty", rvalid, 1'b0);

        push_exp(4'd14, 4, 0, 1'b1, 2'b00);
        do_ar(4'd14, BASE + 32'h10, 8'd0, 3'b010, 2'b01);
        drain("t6_recover_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
